// File: rtl/mamba2_pkg.sv
// Shared constants and the arbiter state encoding for the FP16 multiplier pool.
package mamba2_pkg;

    localparam logic [15:0] FP16_ONE = 16'h3C00;
    localparam logic [15:0] FP16_TWO = 16'h4000;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp16_mult_wrapper.sv
// FP16 multiplier with M_LAT cycles from valid_in to valid_out.
// Denormal inputs and results flush to zero; rounding is round-to-nearest-even.
module fp16_mult_wrapper #(
    parameter int DW    = 16,
    parameter int M_LAT = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          valid_out,
    output logic [DW-1:0] result
);

    function automatic logic [10:0] round_rne(input logic [10:0] mant, input logic rnd,
                                              input logic sticky);
        return mant + {10'd0, rnd & (sticky | mant[0])};
    endfunction

    function automatic logic [15:0] sat_pack(input logic sgn, input int e, input logic [9:0] m);
        if (e >= 31) return {sgn, 5'h1F, 10'h000};
        if (e <= 0)  return {sgn, 15'h0000};
        return {sgn, e[4:0], m};
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
        logic        sgn;
        logic [4:0]  ex;
        logic [4:0]  ey;
        logic [21:0] m;
        logic [10:0] mant;
        logic        rnd;
        logic        sticky;
        int          e;
        sgn = x[15] ^ y[15];
        ex  = x[14:10];
        ey  = y[14:10];
        if ((ex == 5'h1F && x[9:0] != 10'd0) || (ey == 5'h1F && y[9:0] != 10'd0))
            return 16'h7E00;
        if (ex == 5'h1F || ey == 5'h1F)
            return (ex == 5'd0 || ey == 5'd0) ? 16'h7E00 : {sgn, 5'h1F, 10'h000};
        if (ex == 5'd0 || ey == 5'd0)
            return {sgn, 15'h0000};
        m = {11'd0, 1'b1, x[9:0]} * {11'd0, 1'b1, y[9:0]};
        e = int'(ex) + int'(ey) - 15;
        if (m[21]) begin
            mant   = {1'b0, m[20:11]};
            rnd    = m[10];
            sticky = |m[9:0];
            e      = e + 1;
        end else begin
            mant   = {1'b0, m[19:10]};
            rnd    = m[9];
            sticky = |m[8:0];
        end
        mant = round_rne(mant, rnd, sticky);
        // Rounding carried out of the mantissa: renormalise.
        if (mant[10]) begin
            mant = 11'd0;
            e    = e + 1;
        end
        return sat_pack(sgn, e, mant[9:0]);
    endfunction

    logic          vld_q [M_LAT];
    logic          vld_d [M_LAT];
    logic [DW-1:0] res_q [M_LAT];
    logic [DW-1:0] res_d [M_LAT];

    always_comb begin
        vld_d[0] = valid_in;
        res_d[0] = fp16_mul(a, b);
        for (int s = 1; s < M_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            res_d[s] = res_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < M_LAT; s++) vld_q[s] <= 1'b0;
        end else begin
            for (int s = 0; s < M_LAT; s++) vld_q[s] <= vld_d[s];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < M_LAT; s++) res_q[s] <= res_d[s];
    end

    assign valid_out = vld_q[M_LAT-1];
    assign result    = res_q[M_LAT-1];

endmodule

// File: rtl/mult_pool_arb.sv
// Round-robin arbiter sharing one FP16 multiplier lane among NREQ requesters,
// with grant locking and drain. Define MULT_POOL_STATS_EN for per-requester grant/stall counters.
module mult_pool_arb
    import mamba2_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DW    = 16,
    parameter int M_LAT = 6,
    parameter int TW    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_a_flat,
    input  logic [NREQ*DW-1:0] req_b_flat,
    input  logic [NREQ*TW-1:0] req_tag_flat,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    req_ready,
    input  logic               drain,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [TW-1:0]      rsp_tag,
    output logic               idle
`ifdef MULT_POOL_STATS_EN
    ,
    output logic [NREQ*32-1:0] grant_cnt_flat,
    output logic [NREQ*32-1:0] stall_cnt_flat
`endif
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(M_LAT + 3);

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (id == IDW'(NREQ - 1)) return '0;
        return id + IDW'(1);
    endfunction

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  arb_id, sel_id;
    logic            found;
    logic [NREQ-1:0] ready;
    logic            xfer, lock_sel;

    logic            iss_vld_q, iss_vld_d;
    logic [IDW-1:0]  iss_id_q, iss_id_d;
    logic [DW-1:0]   iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [TW-1:0]   iss_tag_q, iss_tag_d;
    logic [IDW-1:0]  id_sh_q  [M_LAT];
    logic [IDW-1:0]  id_sh_d  [M_LAT];
    logic [TW-1:0]   tag_sh_q [M_LAT];
    logic [TW-1:0]   tag_sh_d [M_LAT];

    logic            mult_vld;
    logic [DW-1:0]   mult_res;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [TW-1:0]   rsp_tag_q, rsp_tag_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Round-robin search: lowest valid index at or above rr, else lowest valid overall.
    always_comb begin
        found  = 1'b0;
        arb_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && IDW'(i) >= rr_q) begin
                found  = 1'b1;
                arb_id = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                arb_id = IDW'(i);
            end
        end
        sel_id = (state_q == ST_LOCKED) ? owner_q : arb_id;
        ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            ready[i] = (((state_q == ST_ARB) && found) || (state_q == ST_LOCKED))
                       && (IDW'(i) == sel_id);
        end
    end

    assign req_ready = ready;
    assign xfer      = |(req_valid & ready);
    assign lock_sel  = |(req_lock & ready);
    assign idle      = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        case (state_q)
            ST_ARB: begin
                if (xfer) begin
                    rr_d = next_id(arb_id);
                    if (lock_sel) begin
                        state_d = ST_LOCKED;
                        owner_d = arb_id;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && !lock_sel) begin
                    state_d = ST_ARB;
                    rr_d    = next_id(owner_q);
                end
            end
            ST_DRAIN: begin
                if (!drain && idle) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
        // A beat accepted alongside drain still completes; only later grants stop.
        if (drain && state_q != ST_DRAIN) state_d = ST_DRAIN;
    end

    always_comb begin
        iss_vld_d = xfer;
        iss_id_d  = sel_id;
        iss_a_d   = '0;
        iss_b_d   = '0;
        iss_tag_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                iss_a_d   = req_a_flat[i*DW +: DW];
                iss_b_d   = req_b_flat[i*DW +: DW];
                iss_tag_d = req_tag_flat[i*TW +: TW];
            end
        end
        id_sh_d[0]  = iss_id_q;
        tag_sh_d[0] = iss_tag_q;
        for (int s = 1; s < M_LAT; s++) begin
            id_sh_d[s]  = id_sh_q[s-1];
            tag_sh_d[s] = tag_sh_q[s-1];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        if (mult_vld) begin
            for (int i = 0; i < NREQ; i++) rsp_valid_d[i] = (IDW'(i) == id_sh_q[M_LAT-1]);
            rsp_data_d = mult_res;
            rsp_tag_d  = tag_sh_q[M_LAT-1];
        end
        cnt_d = cnt_q;
        case ({xfer, |rsp_valid_q})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            rr_q        <= '0;
            owner_q     <= '0;
            iss_vld_q   <= 1'b0;
            iss_id_q    <= '0;
            for (int s = 0; s < M_LAT; s++) id_sh_q[s] <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            iss_vld_q   <= iss_vld_d;
            iss_id_q    <= iss_id_d;
            for (int s = 0; s < M_LAT; s++) id_sh_q[s] <= id_sh_d[s];
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        iss_a_q   <= iss_a_d;
        iss_b_q   <= iss_b_d;
        iss_tag_q <= iss_tag_d;
        for (int s = 0; s < M_LAT; s++) tag_sh_q[s] <= tag_sh_d[s];
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;

    fp16_mult_wrapper #(
        .DW    (DW),
        .M_LAT (M_LAT)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (iss_vld_q),
        .a         (iss_a_q),
        .b         (iss_b_q),
        .valid_out (mult_vld),
        .result    (mult_res)
    );

`ifdef MULT_POOL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] grant_cnt_q [NREQ];
    logic [31:0] grant_cnt_d [NREQ];
    logic [31:0] stall_cnt_q [NREQ];
    logic [31:0] stall_cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt_d[i] = (req_valid[i] && ready[i])  ? sat_inc(grant_cnt_q[i]) : grant_cnt_q[i];
            stall_cnt_d[i] = (req_valid[i] && !ready[i]) ? sat_inc(stall_cnt_q[i]) : stall_cnt_q[i];
            grant_cnt_flat[i*32 +: 32] = grant_cnt_q[i];
            stall_cnt_flat[i*32 +: 32] = stall_cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end
`endif

endmodule
